// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
// Shares one external combinational AES S-box between two requesters. The
// key-expansion requester sends one 32-bit word. The subBytes requester sends
// one 128-bit state. A granted request is copied into an operand register.
// Its bytes are then streamed through the S-box, one byte per cycle, into a
// result register. The result is held behind a valid/ready handshake until
// the owning requester takes it. Only one request is in flight at a time, and
// requests cannot be preempted.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   kx_req_valid/kx_req_ready    key-expansion request handshake
//   kx_word[31:0]                word to substitute, byte i = [8i+7:8i]
//   kx_rsp_valid/kx_rsp_ready    key-expansion result handshake
//   kx_rsp_word[31:0]            substituted word
//   sb_req_valid/sb_req_ready    subBytes request handshake
//   sb_state[127:0]              state to substitute, byte i = [8i+7:8i]
//   sb_rsp_valid/sb_rsp_ready    subBytes result handshake
//   sb_rsp_state[127:0]          substituted state
//   sbox_lhs[7:0]                byte presented to the shared S-box
//   sbox_o[7:0]                  S-box output, combinational from sbox_lhs
module sbox_share_arbiter #(
  parameter bit KX_PRIORITY = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kx_req_valid,
  output logic         kx_req_ready,
  input  logic [31:0]  kx_word,
  output logic         kx_rsp_valid,
  input  logic         kx_rsp_ready,
  output logic [31:0]  kx_rsp_word,
  input  logic         sb_req_valid,
  output logic         sb_req_ready,
  input  logic [127:0] sb_state,
  output logic         sb_rsp_valid,
  input  logic         sb_rsp_ready,
  output logic [127:0] sb_rsp_state,
  output logic [7:0]   sbox_lhs,
  input  logic [7:0]   sbox_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RSP} state_e;
  typedef enum logic {REQ_KX = 1'b0, REQ_SB = 1'b1} req_e;

  state_e       state_q, state_d;
  req_e         owner_q, owner_d;
  req_e         last_grant_q, last_grant_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   last_q, last_d;
  logic [127:0] operand_q, operand_d;
  logic [127:0] result_q, result_d;
  logic         kx_rsp_valid_q, kx_rsp_valid_d;
  logic         sb_rsp_valid_q, sb_rsp_valid_d;

  logic         grant_kx;
  logic         grant_sb;

  // Grants are offered only in IDLE, and only to a requester whose valid is
  // high, so a ready never rises without its matching valid.
  always_comb begin
    // NOTE: every signal written in this block gets a default first. A path
    // that skips the assignment would otherwise infer a latch.
    grant_kx = 1'b0;
    grant_sb = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (kx_req_valid && sb_req_valid) begin
        // On a tie, round-robin hands the grant to whoever was not served last.
        if (KX_PRIORITY || last_grant_q == REQ_SB) grant_kx = 1'b1;
        else                                       grant_sb = 1'b1;
      end else if (kx_req_valid) begin
        grant_kx = 1'b1;
      end else if (sb_req_valid) begin
        grant_sb = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    idx_d          = idx_q;
    last_d         = last_q;
    operand_d      = operand_q;
    result_d       = result_q;
    kx_rsp_valid_d = kx_rsp_valid_q;
    sb_rsp_valid_d = sb_rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_kx) begin
          operand_d    = {96'b0, kx_word};
          owner_d      = REQ_KX;
          last_grant_d = REQ_KX;
          idx_d        = 4'd0;
          last_d       = 4'd3;
          state_d      = ST_RUN;
        end else if (grant_sb) begin
          operand_d    = sb_state;
          owner_d      = REQ_SB;
          last_grant_d = REQ_SB;
          idx_d        = 4'd0;
          last_d       = 4'd15;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d[{idx_q, 3'b000} +: 8] = sbox_o;
        if (idx_q == last_q) begin
          state_d        = ST_RSP;
          kx_rsp_valid_d = (owner_q == REQ_KX);
          sb_rsp_valid_d = (owner_q == REQ_SB);
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_RSP: begin
        // A new grant has to wait for the following IDLE cycle.
        if ((owner_q == REQ_KX && kx_rsp_ready) ||
            (owner_q == REQ_SB && sb_rsp_ready)) begin
          state_d        = ST_IDLE;
          kx_rsp_valid_d = 1'b0;
          sb_rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The operand and result registers are ordinary flops, so they are reset
  // together with the control state.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments. Every flop then sees
    // the values from before the edge, whatever order the statements run in.
    if (rst) begin
      state_q        <= ST_IDLE;
      owner_q        <= REQ_KX;
      last_grant_q   <= REQ_SB;
      idx_q          <= 4'd0;
      last_q         <= 4'd0;
      operand_q      <= '0;
      result_q       <= '0;
      kx_rsp_valid_q <= 1'b0;
      sb_rsp_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      idx_q          <= idx_d;
      last_q         <= last_d;
      operand_q      <= operand_d;
      result_q       <= result_d;
      kx_rsp_valid_q <= kx_rsp_valid_d;
      sb_rsp_valid_q <= sb_rsp_valid_d;
    end
  end

  // The reset is synchronous, so the registers still hold old values during
  // the first cycle of a reset. Gating with rst keeps every output at zero for
  // as long as rst is high.
  assign kx_req_ready = grant_kx;
  assign sb_req_ready = grant_sb;
  assign kx_rsp_valid = kx_rsp_valid_q && !rst;
  assign sb_rsp_valid = sb_rsp_valid_q && !rst;
  assign kx_rsp_word  = rst ? 32'b0  : result_q[31:0];
  assign sb_rsp_state = rst ? 128'b0 : result_q;
  assign sbox_lhs     = (state_q == ST_RUN && !rst) ? operand_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: doc/sbox_share_arbiter.md
# sbox_share_arbiter

Time-multiplexes one combinational AES S-box between two requesters: the key-expansion subWord path (4-byte words) and the cipher subBytes path (16-byte states). It sits between the key scheduler and the round datapath in the area-reduced cipher. One request is granted at a time and its bytes are streamed through the shared S-box at one byte per cycle. Each requester gets a registered result behind a valid/ready handshake.

## Interface
- `KX_PRIORITY`, default 0: 0 = round-robin between requesters; 1 = key-expansion always wins a tie.
- `clk`  in  1  clock; every register samples on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `kx_req_valid`  in  1  key-expansion request valid.
- `kx_req_ready`  out  1  key-expansion request accepted this cycle.
- `kx_word`  in  32  AESWord to substitute; byte i = bits [8i+7:8i].
- `kx_rsp_valid`  out  1  key-expansion result valid.
- `kx_rsp_ready`  in  1  key-expansion result consumed.
- `kx_rsp_word`  out  32  substituted word.
- `sb_req_valid`  in  1  subBytes request valid.
- `sb_req_ready`  out  1  subBytes request accepted this cycle.
- `sb_state`  in  128  AES state; byte i = bits [8i+7:8i].
- `sb_rsp_valid`  out  1  subBytes result valid.
- `sb_rsp_ready`  in  1  subBytes result consumed.
- `sb_rsp_state`  out  128  substituted state.
- `sbox_lhs`  out  8  byte driven into the shared S-box.
- `sbox_o`  in  8  S-box output; combinational from `sbox_lhs`, same cycle.

## Operation
- FSM states:
  - IDLE: arbitrate between requesters.
  - RUN: stream bytes through the S-box.
  - RSP: hold the result.
- IDLE:
  - `kx_req_ready`/`sb_req_ready` are combinational. Only the granted requester sees ready=1, and only while its valid=1.
  - Grant with `KX_PRIORITY`=1: kx whenever kx valid.
  - Grant with `KX_PRIORITY`=0, both valid: the requester that was not last granted. `last_grant` resets to sb, so kx wins the first tie.
  - Only one valid: that requester is granted.
  - Handshake (valid & ready): latch the input into a 128-bit operand register and zero-extend a kx word. Latch `owner`. Set `idx`=0 and `last`=3 (kx) or 15 (sb). Update `last_grant`. Go to RUN.
- RUN:
  - `sbox_lhs` = operand byte `idx`.
  - `sbox_o` is written into result byte `idx`.
  - If `idx`==`last` go to RSP, else `idx`+1.
  - `idx` is a 4-bit counter and never wraps within a request.
- RSP:
  - `owner`'s rsp_valid=1 and holds until that requester's rsp_ready=1. On that cycle go to IDLE.
  - A new request can be granted on the first IDLE cycle, not in the same cycle as the rsp handshake.
- `kx_rsp_word` = result[31:0] and `sb_rsp_state` = result[127:0], both driven continuously from the result register. They are meaningful only while the matching valid is high.
- `sbox_lhs` = 0 outside RUN.
- Requests are non-preemptive: a new higher-priority request waits until the current one returns to IDLE.
- Input data is sampled only at the handshake. Later changes to `kx_word`/`sb_state` do not affect the request in flight.

## Timing
- Reset values:
  - FSM=IDLE, `idx`=0, operand=0, result=0, `last_grant`=sb, `owner`=kx.
  - Every output is 0 while `rst`=1: both ready signals, both rsp_valid signals, `kx_rsp_word`, `sb_rsp_state`, `sbox_lhs`.
- `rst` mid-operation aborts immediately. No response is produced and the next cycle is IDLE.
- Latency, with the handshake in cycle 0:
  - kx: RUN in cycles 1–4, `kx_rsp_valid` rises in cycle 5.
  - sb: RUN in cycles 1–16, `sb_rsp_valid` rises in cycle 17.
- Throughput with rsp_ready held at 1:
  - kx: one word per 6 cycles.
  - sb: one state per 18 cycles.
- The two ready signals are never high together. The two rsp_valid signals are never high together.
- A requester may drop valid before being granted without side effects.

## Test plan
- Single kx: `kx_word`=0x00010053, rsp_ready=1 → `kx_rsp_valid` in cycle 5 with 0x637c63ed, single pulse; `sbox_lhs` sequence 0x53, 0x00, 0x01, 0x00.
- Single sb: `sb_state`=0 → `sb_rsp_valid` in cycle 17 with all bytes 0x63; all-0xff state → all bytes 0x16.
- Simultaneous requests, `KX_PRIORITY`=0, both held valid for 4 requests → grants kx, sb, kx, sb; `KX_PRIORITY`=1 → kx every time while kx valid.
- Backpressure: `kx_rsp_ready`=0 for 10 cycles after valid → valid and data held stable, `sb_req_ready` stays 0, sb granted on the cycle after the kx rsp handshake.
- `rst` pulsed in cycle 8 of an sb request → no `sb_rsp_valid`; all outputs 0; a subsequent kx request completes with correct data and normal latency.
- Change `sb_state` during RUN → response reflects the value sampled at the handshake.
